// File: rtl/mulalu.sv
// mulalu: multi-cycle multiply / restoring-divide unit returning HI/LO write pulses
`ifndef FUNC_MUL
`define FUNC_MUL 5'b00001
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 5'b00010
`endif

module mulalu #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        mulalu_sign,
  input  logic [4:0]  mulalu_func,
  input  logic [31:0] source_a,
  input  logic [31:0] source_b,
  output logic        stall,
  output logic        hi_write,
  output logic [31:0] hi_write_data,
  output logic        lo_write,
  output logic [31:0] lo_write_data
);
  localparam int CW = ($clog2(MUL_LAT) > 5) ? $clog2(MUL_LAT) : 5;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic neg_q, neg_r, start;
  logic [31:0] ma, mb, rem, quo, abs_a, abs_b, nrem, nquo;
  logic [32:0] sh;
  logic [33:0] diff;
  logic [63:0] prod;
  // Start detect, pipeline hold, strobes and one restoring divide step
  always_comb begin
    start = rst_n && state == S_IDLE && !flush &&
            (mulalu_func == `FUNC_MUL || mulalu_func == `FUNC_DIV);
    stall = start || (!flush && (state == S_MUL || state == S_DIV));
    hi_write = state == S_DONE && !flush;
    lo_write = state == S_DONE && !flush;
    abs_a = (mulalu_sign && source_a[31]) ? -source_a : source_a;
    abs_b = (mulalu_sign && source_b[31]) ? -source_b : source_b;
    sh = {rem, quo[31]};
    diff = {1'b0, sh} - {2'b0, mb};
    nrem = diff[33] ? sh[31:0] : diff[31:0];
    nquo = {quo[30:0], !diff[33]};
    prod = 64'(ma) * 64'(mb);
  end
  // Operation sequencer: latch operands, iterate, then apply result signs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ma <= '0;
      mb <= '0;
      rem <= '0;
      quo <= '0;
      hi_write_data <= '0;
      lo_write_data <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          ma <= abs_a;
          mb <= abs_b;
          rem <= '0;
          quo <= abs_a;
          neg_q <= mulalu_sign && (source_a[31] ^ source_b[31]);
          neg_r <= mulalu_sign && source_a[31];
          cnt <= '0;
          state <= mulalu_func == `FUNC_MUL ? S_MUL : S_DIV;
        end
        S_MUL: if (cnt == CW'(MUL_LAT - 1)) begin
          {hi_write_data, lo_write_data} <= neg_q ? -prod : prod;
          state <= S_DONE;
        end else cnt <= cnt + 1'b1;
        S_DIV: if (cnt == CW'(31)) begin
          lo_write_data <= neg_q ? -nquo : nquo;
          hi_write_data <= neg_r ? -nrem : nrem;
          state <= S_DONE;
        end else begin
          cnt <= cnt + 1'b1;
          rem <= nrem;
          quo <= nquo;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
